// File: rtl/mem_wb_lsu_pkg.sv
// rtl/mem_wb_lsu_pkg.sv - shared encodings for the memory-stage LSU and MEM/WB register
package mem_wb_lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_TIMEOUT  = 2'b10
  } exc_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/mem_wb_lsu_align.sv
// rtl/mem_wb_lsu_align.sv - byte-lane strobes, store replication, load extension, misalign check
module mem_wb_lsu_align
  import mem_wb_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        aligned_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{off_i, 3'b000} +: 8];
  assign half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Undefined size encodings fall through to a full word access.
  always_comb begin
    aligned_o = 1'b1;
    wstrb_o   = 4'b1111;
    wdata_o   = wdata_i;
    rdata_o   = rdata_i;
    case (funct3_i)
      F3_B, F3_BU: begin
        wstrb_o = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~funct3_i[2] & byte_sel[7]}}, byte_sel};
      end
      F3_H, F3_HU: begin
        aligned_o = ~off_i[0];
        wstrb_o   = 4'b0011 << off_i;
        wdata_o   = {2{wdata_i[15:0]}};
        rdata_o   = {{16{~funct3_i[2] & half_sel[15]}}, half_sel};
      end
      default: aligned_o = (off_i == 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_wb_lsu.sv
// rtl/mem_wb_lsu.sv - memory-stage load/store unit with req/ready port and MEM/WB register
module mem_wb_lsu
  import mem_wb_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic [1:0]  ResultSrcW,
  output logic        RegWriteW,
  output logic [1:0]  ExcW
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  lsu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        mem_op, aligned, misaligned, abort;
  logic [31:0] load_data;

  logic [31:0] alu_w_q, alu_w_d, rdata_w_q, rdata_w_d, pc4_w_q, pc4_w_d;
  logic [4:0]  rd_w_q, rd_w_d;
  logic [1:0]  src_w_q, src_w_d, exc_w_q, exc_w_d;
  logic        regwrite_w_q, regwrite_w_d;

  mem_wb_lsu_align u_align (
    .funct3_i  (Funct3M),
    .off_i     (ALUResultM[1:0]),
    .wdata_i   (WriteDataM),
    .rdata_i   (dmem_rdata),
    .aligned_o (aligned),
    .wstrb_o   (dmem_wstrb),
    .wdata_o   (dmem_wdata),
    .rdata_o   (load_data)
  );

  assign mem_op     = MemReadM | MemWriteM;
  assign misaligned = mem_op & ~aligned;
  assign dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem_we    = MemWriteM;
  assign dmem_req   = ~reset & ((state_q == ST_WAIT) | (mem_op & aligned));
  // The last wait cycle aborts unless ready shows up in that same cycle.
  assign abort      = (state_q == ST_WAIT) & ~dmem_ready & (cnt_q == CNT_LAST);
  assign StallM     = dmem_req & ~dmem_ready & ~abort;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_w_d      = ALUResultM;
    rdata_w_d    = abort ? 32'h0 : load_data;
    pc4_w_d      = PCPlus4M;
    rd_w_d       = RdM;
    src_w_d      = ResultSrcM;
    regwrite_w_d = RegWriteM & ~misaligned & ~abort;
    exc_w_d      = abort ? EXC_TIMEOUT : (misaligned ? EXC_MISALIGN : EXC_NONE);
    case (state_q)
      ST_IDLE: begin
        if (dmem_req && !dmem_ready) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        if (dmem_ready || abort) state_d = ST_IDLE;
        else cnt_d = cnt_q + CW'(1);
      end
    endcase
    if (StallM) begin
      alu_w_d      = alu_w_q;
      rdata_w_d    = rdata_w_q;
      pc4_w_d      = pc4_w_q;
      rd_w_d       = rd_w_q;
      src_w_d      = src_w_q;
      regwrite_w_d = 1'b0;
      exc_w_d      = EXC_NONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_w_q      <= '0;
      rdata_w_q    <= '0;
      pc4_w_q      <= '0;
      rd_w_q       <= '0;
      src_w_q      <= '0;
      regwrite_w_q <= 1'b0;
      exc_w_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_w_q      <= alu_w_d;
      rdata_w_q    <= rdata_w_d;
      pc4_w_q      <= pc4_w_d;
      rd_w_q       <= rd_w_d;
      src_w_q      <= src_w_d;
      regwrite_w_q <= regwrite_w_d;
      exc_w_q      <= exc_w_d;
    end
  end

  assign ALUResultW = alu_w_q;
  assign ReadDataW  = rdata_w_q;
  assign PCPlus4W   = pc4_w_q;
  assign RdW        = rd_w_q;
  assign ResultSrcW = src_w_q;
  assign RegWriteW  = regwrite_w_q;
  assign ExcW       = exc_w_q;

endmodule

// File: tb/tb_mem_wb_lsu.sv
// tb/tb_mem_wb_lsu.sv - directed self-checking bench for mem_wb_lsu
module tb_mem_wb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemReadM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic        dmem_req, dmem_we, dmem_ready, StallM;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic [1:0]  ResultSrcW, ExcW;
  logic        RegWriteW;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_lsu #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RdM        (RdM),
    .PCPlus4M   (PCPlus4M),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wstrb (dmem_wstrb),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .StallM     (StallM),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .RdW        (RdW),
    .ResultSrcW (ResultSrcW),
    .RegWriteW  (RegWriteW),
    .ExcW       (ExcW)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] addr, input logic rd,
                       input logic wr, input logic [31:0] wd);
    Funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    MemReadM   = rd;
    MemWriteM  = wr;
    RegWriteM  = rd;
    ResultSrcM = rd ? 2'b01 : 2'b00;
    RdM        = 5'd7;
    PCPlus4M   = addr + 32'd4;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    drive(3'b010, 32'h100, 1'b1, 1'b0, 32'h0);
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_w", {ALUResultW ^ ReadDataW ^ PCPlus4W}, 32'h0);
    chk("rst_ctl", {23'h0, RdW, ResultSrcW, RegWriteW, ExcW}, 32'h0);
    step();
    reset = 1'b0;
    #1;
    chk("lw0_stall", {31'h0, StallM}, 32'h0);
    chk("lw0_req", {31'h0, dmem_req}, 32'h1);
    chk("lw0_addr", dmem_addr, 32'h100);
    step();
    chk("lw0_data", ReadDataW, 32'hDEADBEEF);
    chk("lw0_ctl", {25'h0, RdW, RegWriteW, ResultSrcW}, {25'h0, 5'd7, 1'b1, 2'b01});
    chk("lw0_exc", {30'h0, ExcW}, 32'h0);

    dmem_ready = 1'b0;
    dmem_rdata = 32'h80112233;
    drive(3'b000, 32'h103, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("lb_stall", {31'h0, StallM}, 32'h1);
      step();
      chk("lb_bubble", {30'h0, RegWriteW, ExcW[0]}, 32'h0);
    end
    dmem_ready = 1'b1;
    #1;
    chk("lb_done_stall", {31'h0, StallM}, 32'h0);
    step();
    chk("lb_data", ReadDataW, 32'hFFFFFF80);
    chk("lb_we", {31'h0, RegWriteW}, 32'h1);
    drive(3'b100, 32'h103, 1'b1, 1'b0, 32'h0);
    step();
    chk("lbu_data", ReadDataW, 32'h00000080);

    dmem_rdata = 32'h80012233;
    drive(3'b001, 32'h102, 1'b1, 1'b0, 32'h0);
    step();
    chk("lh_data", ReadDataW, 32'hFFFF8001);
    drive(3'b101, 32'h102, 1'b1, 1'b0, 32'h0);
    step();
    chk("lhu_data", ReadDataW, 32'h00008001);

    drive(3'b001, 32'h202, 1'b0, 1'b1, 32'h0000ABCD);
    chk("sh_strb", {28'h0, dmem_wstrb}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_addr", dmem_addr, 32'h200);
    chk("sh_we", {31'h0, dmem_we}, 32'h1);
    step();
    chk("sh_w", {29'h0, RegWriteW, ExcW}, 32'h0);
    drive(3'b000, 32'h201, 1'b0, 1'b1, 32'h0000ABCD);
    chk("sb_strb", {28'h0, dmem_wstrb}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hCDCDCDCD);
    step();

    dmem_ready = 1'b0;
    drive(3'b010, 32'h101, 1'b1, 1'b0, 32'h0);
    chk("mis_req", {31'h0, dmem_req}, 32'h0);
    chk("mis_stall", {31'h0, StallM}, 32'h0);
    step();
    chk("mis_w", {29'h0, RegWriteW, ExcW}, 32'h1);

    drive(3'b010, 32'h300, 1'b1, 1'b0, 32'h0);
    n = 0;
    while (StallM && n < 40) begin
      n++;
      step();
    end
    chk("to_stall_cycles", n, 32'd15);
    step();
    chk("to_w", {29'h0, RegWriteW, ExcW}, 32'h2);
    chk("to_data", ReadDataW, 32'h0);
    chk("to_alu", ALUResultW, 32'h300);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h12345678;
    drive(3'b010, 32'h104, 1'b1, 1'b0, 32'h0);
    chk("post_to_stall", {31'h0, StallM}, 32'h0);
    step();
    chk("post_to_data", ReadDataW, 32'h12345678);
    chk("post_to_w", {29'h0, RegWriteW, ExcW}, 32'h4);

    dmem_ready = 1'b0;
    drive(3'b010, 32'h308, 1'b1, 1'b0, 32'h0);
    repeat (15) step();
    dmem_ready = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    #1;
    step();
    chk("race_w", {29'h0, RegWriteW, ExcW}, 32'h4);
    chk("race_data", ReadDataW, 32'hCAFEF00D);

    dmem_ready = 1'b0;
    drive(3'b010, 32'h400, 1'b1, 1'b0, 32'h0);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rw_req", {31'h0, dmem_req}, 32'h0);
    chk("rw_alu", ALUResultW, 32'h0);
    chk("rw_pc4", PCPlus4W, 32'h0);
    chk("rw_ctl", {23'h0, RdW, ResultSrcW, RegWriteW, ExcW}, 32'h0);
    step();
    reset = 1'b0;
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0BADC0DE;
    drive(3'b010, 32'h104, 1'b1, 1'b0, 32'h0);
    chk("rr_req", {31'h0, dmem_req}, 32'h1);
    chk("rr_stall", {31'h0, StallM}, 32'h0);
    step();
    chk("rr_data", ReadDataW, 32'h0BADC0DE);
    chk("rr_pc4", PCPlus4W, 32'h108);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
